// File: rtl/dmem_pair_sched_pkg.sv
// Shared types for the dual-pipe data-memory scheduler: request payload,
// response-queue entry, slot indices and scheduler FSM states.
package dmem_pair_sched_pkg;

  localparam int unsigned SLOT_A = 0;
  localparam int unsigned SLOT_B = 1;

  typedef struct packed {
    logic [31:0] va;
    logic        we;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

  // One queue entry per accepted downstream transaction; a and b mark which
  // pipes own the response, kill marks a transaction squashed by flush.
  typedef struct packed {
    logic a;
    logic b;
    logic kill;
  } rq_entry_t;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_SPLIT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/dmem_pair_sched_if.sv
// Bundle of LSU-side (u_*) and MMU-side (d_*) signals around the scheduler.
// Handshakes: u_req/u_addr_ok and d_req/d_addr_ok transfer a request in the
// cycle both are high; *_data_ok is a one-cycle, in-order response strobe.
interface dmem_pair_sched_if;
  import dmem_pair_sched_pkg::*;

  logic     [1:0]       u_req;
  mem_req_t [1:0]       u_info;
  logic     [1:0]       u_addr_ok;
  logic     [1:0]       u_data_ok;
  logic     [1:0][31:0] u_rdata;

  logic     [1:0]       d_req;
  mem_req_t [1:0]       d_info;
  logic     [1:0]       d_addr_ok;
  logic     [1:0]       d_data_ok;
  logic     [1:0][31:0] d_rdata;

  modport slave (
    input  u_req, u_info, d_addr_ok, d_data_ok, d_rdata,
    output u_addr_ok, u_data_ok, u_rdata, d_req, d_info
  );

  modport master (
    output u_req, u_info, d_addr_ok, d_data_ok, d_rdata,
    input  u_addr_ok, u_data_ok, u_rdata, d_req, d_info
  );

endinterface

// File: rtl/dmem_pair_sched_resp_fifo.sv
// In-order response queue: ring of rq_entry_t with wrap-bit pointers,
// plus a kill_all that marks every stored (and incoming) entry as squashed.
module dmem_resp_fifo
  import dmem_pair_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      push,
  input  rq_entry_t push_entry,
  input  logic      pop,
  input  logic      kill_all,
  output rq_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rq_entry_t [DEPTH-1:0] r_mem;
  logic      [AW:0]      r_wptr;
  logic      [AW:0]      r_rptr;
  logic                  w_push;
  logic                  w_pop;
  logic      [AW:0]      w_one;

  assign w_one  = {{AW{1'b0}}, 1'b1};
  assign empty  = (r_wptr == r_rptr);
  assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign head   = r_mem[r_rptr[AW-1:0]];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (kill_all) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[i].kill <= 1'b1;
        end
      end
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= '{a: push_entry.a, b: push_entry.b,
                                   kill: push_entry.kill | kill_all};
        r_wptr <= r_wptr + w_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + w_one;
      end
    end
  end

endmodule

// File: rtl/dmem_pair_sched.sv
// Schedules LSU pipes A (older) and B (younger) onto MMU ports d1/d2 while
// keeping program order, and steers in-order MMU responses back per pipe.
module dmem_pair_sched
  import dmem_pair_sched_pkg::*;
#(
  parameter int RQ_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  output logic                    idle,
  dmem_pair_sched_if.slave        bus,
  output sched_state_t            o_dbg_state
);

  logic         [1:0] r_hold_v;
  mem_req_t     [1:0] r_hold;
  logic               r_bfirst;
  sched_state_t       r_state;

  logic               w_rq_full;
  logic               w_rq_empty;
  rq_entry_t          w_head;
  rq_entry_t          w_push_entry;
  logic               w_issue_en;
  logic         [1:0] w_d_req;
  logic         [1:0] w_acc;
  logic         [1:0] w_cap;
  logic               w_to_split;

  // Nothing is offered while the queue cannot record it or while flushing.
  assign w_issue_en = ~w_rq_full & ~flush;

  // A waits behind an older held B (bfirst) and while B is re-issued alone.
  assign w_d_req[SLOT_A] = w_issue_en & r_hold_v[SLOT_A] & ~r_bfirst & (r_state == ST_ISSUE);
  assign w_d_req[SLOT_B] = w_issue_en & r_hold_v[SLOT_B];
  assign w_acc           = w_d_req & bus.d_addr_ok;

  // A holding register is refilled only when empty or drained this cycle.
  assign w_cap[SLOT_A] = bus.u_req[SLOT_A] & ~flush & (~r_hold_v[SLOT_A] | w_acc[SLOT_A])
                         & (r_state == ST_ISSUE);
  assign w_cap[SLOT_B] = bus.u_req[SLOT_B] & ~flush & (~r_hold_v[SLOT_B] | w_acc[SLOT_B]);

  assign w_to_split = w_acc[SLOT_A] & r_hold_v[SLOT_B] & ~bus.d_addr_ok[SLOT_B];

  assign bus.u_addr_ok = w_cap;
  assign bus.d_req     = w_d_req;
  assign bus.d_info    = r_hold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold_v <= '0;
      r_hold   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_cap[i]) begin
          r_hold_v[i] <= 1'b1;
          r_hold[i]   <= bus.u_info[i];
        end else if (flush || w_acc[i]) begin
          r_hold_v[i] <= 1'b0;
        end
      end
    end
  end

  // FSM and age bit. bfirst marks a held, unissued B that is older than A.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_ISSUE;
      r_bfirst <= 1'b0;
    end else begin
      if (flush || w_acc[SLOT_B]) begin
        r_bfirst <= 1'b0;
      end else if (w_cap[SLOT_A] && r_hold_v[SLOT_B]) begin
        r_bfirst <= 1'b1;
      end

      if (flush) begin
        r_state <= ST_ISSUE;
      end else begin
        case (r_state)
          ST_ISSUE: if (w_to_split)     r_state <= ST_SPLIT;
          ST_SPLIT: if (w_acc[SLOT_B])  r_state <= ST_ISSUE;
          default:                      r_state <= ST_ISSUE;
        endcase
      end
    end
  end

  assign o_dbg_state = r_state;

  assign w_push_entry = '{a: w_acc[SLOT_A], b: w_acc[SLOT_B], kill: 1'b0};

  dmem_resp_fifo #(
    .DEPTH (RQ_DEPTH)
  ) u_resp_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (|w_acc),
    .push_entry (w_push_entry),
    .pop        (|bus.d_data_ok),
    .kill_all   (flush),
    .head       (w_head),
    .full       (w_rq_full),
    .empty      (w_rq_empty)
  );

  // Responses with no matching queue entry (e.g. after reset) are dropped.
  assign bus.u_data_ok[SLOT_A] = bus.d_data_ok[SLOT_A] & ~w_rq_empty & w_head.a & ~w_head.kill;
  assign bus.u_data_ok[SLOT_B] = bus.d_data_ok[SLOT_B] & ~w_rq_empty & w_head.b & ~w_head.kill;
  assign bus.u_rdata           = bus.d_rdata;

  assign idle = ~r_hold_v[SLOT_A] & ~r_hold_v[SLOT_B] & w_rq_empty;

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
    !((|bus.d_data_ok) && w_rq_empty));

  a_no_issue_when_full: assert property (@(posedge clk) disable iff (!resetn)
    !((|w_d_req) && w_rq_full));

endmodule

// File: tb/tb_dmem_pair_sched.sv
// Directed bench for dmem_pair_sched: pairing, split re-issue, B-first
// ordering, queue-full stall, flush squash and asynchronous reset.
module tb_dmem_pair_sched;
  import dmem_pair_sched_pkg::*;

  logic         clk;
  logic         resetn;
  logic         flush;
  logic         idle;
  sched_state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  dmem_pair_sched_if bus ();

  dmem_pair_sched #(.RQ_DEPTH(2)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .idle        (idle),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  function automatic mem_req_t mk_req(input logic [31:0] va);
    mem_req_t r;
    r.va    = va;
    r.we    = 1'b0;
    r.size  = 2'd2;
    r.wstrb = 4'hf;
    r.wdata = ~va;
    return r;
  endfunction

  task automatic clr_inputs();
    flush         = 1'b0;
    bus.u_req     = '0;
    bus.u_info    = '0;
    bus.d_addr_ok = '0;
    bus.d_data_ok = '0;
    bus.d_rdata   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: each response cycle is compared against the next expected entry
  task automatic resp(input logic [1:0] dok, input logic [31:0] r0, input logic [31:0] r1,
                      input string tag);
    logic [1:0] e;
    bus.d_data_ok  = dok;
    bus.d_rdata[0] = r0;
    bus.d_rdata[1] = r1;
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_dok"}, 32'(bus.u_data_ok), 32'(e));
      if (e[0]) chk({tag, "_rd0"}, bus.u_rdata[0], r0);
      if (e[1]) chk({tag, "_rd1"}, bus.u_rdata[1], r1);
    end
    tick();
    bus.d_data_ok = '0;
    bus.d_rdata   = '0;
  endtask

  initial begin
    clr_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle",  32'(idle), 32'd1);
    chk("rst_dreq",  32'(bus.d_req), 32'd0);
    chk("rst_aok",   32'(bus.u_addr_ok), 32'd0);
    chk("rst_dok",   32'(bus.u_data_ok), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_ISSUE));
    resetn = 1'b1;
    tick();

    // A+B same line, accepted together
    bus.u_req     = 2'b11;
    bus.u_info[0] = mk_req(32'h100);
    bus.u_info[1] = mk_req(32'h104);
    #1;
    chk("pair_aok", 32'(bus.u_addr_ok), 32'd3);
    chk("pair_dreq_lat", 32'(bus.d_req), 32'd0);
    tick();
    bus.u_req = 2'b00;
    #1;
    chk("pair_dreq", 32'(bus.d_req), 32'd3);
    chk("pair_va0", bus.d_info[0].va, 32'h100);
    chk("pair_va1", bus.d_info[1].va, 32'h104);
    chk("pair_idle0", 32'(idle), 32'd0);
    bus.d_addr_ok = 2'b11;
    tick();
    bus.d_addr_ok = 2'b00;
    #1;
    chk("pair_dreq_done", 32'(bus.d_req), 32'd0);
    exp_q.push_back(2'b11);
    resp(2'b11, 32'hAAAA_0001, 32'hBBBB_0001, "pair");
    chk("pair_idle1", 32'(idle), 32'd1);

    // A+B conflicting: B refused, split re-issue
    bus.u_req     = 2'b11;
    bus.u_info[0] = mk_req(32'h200);
    bus.u_info[1] = mk_req(32'h300);
    tick();
    bus.u_req     = 2'b00;
    bus.d_addr_ok = 2'b01;
    #1;
    chk("split_dreq0", 32'(bus.d_req), 32'd3);
    tick();
    bus.d_addr_ok = 2'b00;
    #1;
    chk("split_state", 32'(dbg_state), 32'(ST_SPLIT));
    chk("split_dreq1", 32'(bus.d_req), 32'd2);
    chk("split_va1", bus.d_info[1].va, 32'h300);
    bus.u_req     = 2'b01;
    bus.u_info[0] = mk_req(32'h210);
    #1;
    chk("split_ablock", 32'(bus.u_addr_ok), 32'd0);
    bus.u_req     = 2'b00;
    bus.d_addr_ok = 2'b10;
    tick();
    bus.d_addr_ok = 2'b00;
    #1;
    chk("split_back", 32'(dbg_state), 32'(ST_ISSUE));
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    resp(2'b01, 32'h0000_2001, 32'h0, "split_r0");
    resp(2'b10, 32'h0, 32'h0000_3001, "split_r1");
    chk("split_idle", 32'(idle), 32'd1);

    // B held and refused, older than a later A
    bus.u_req     = 2'b10;
    bus.u_info[1] = mk_req(32'h400);
    tick();
    bus.u_req     = 2'b01;
    bus.u_info[0] = mk_req(32'h500);
    #1;
    chk("bf_aok", 32'(bus.u_addr_ok), 32'd1);
    tick();
    bus.u_req = 2'b00;
    #1;
    chk("bf_dreq_b", 32'(bus.d_req), 32'd2);
    bus.d_addr_ok = 2'b10;
    tick();
    bus.d_addr_ok = 2'b00;
    #1;
    chk("bf_dreq_a", 32'(bus.d_req), 32'd1);
    chk("bf_va0", bus.d_info[0].va, 32'h500);
    bus.d_addr_ok = 2'b01;
    tick();
    bus.d_addr_ok = 2'b00;
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    resp(2'b10, 32'h0, 32'h0000_4001, "bf_r0");
    resp(2'b01, 32'h0000_5001, 32'h0, "bf_r1");

    // two unanswered issues fill the queue
    bus.u_req     = 2'b01;
    bus.u_info[0] = mk_req(32'h600);
    tick();
    bus.u_info[0] = mk_req(32'h604);
    bus.d_addr_ok = 2'b01;
    tick();
    bus.u_info[0] = mk_req(32'h608);
    tick();
    bus.u_req     = 2'b00;
    bus.d_addr_ok = 2'b00;
    #1;
    chk("full_dreq", 32'(bus.d_req), 32'd0);
    chk("full_va0", bus.d_info[0].va, 32'h608);
    exp_q.push_back(2'b01);
    resp(2'b01, 32'h0000_6001, 32'h0, "full_r0");
    chk("full_dreq_resume", 32'(bus.d_req), 32'd1);

    // refill to 2 in flight with A held, then flush
    bus.d_addr_ok = 2'b01;
    bus.u_req     = 2'b01;
    bus.u_info[0] = mk_req(32'h60C);
    tick();
    bus.d_addr_ok = 2'b00;
    bus.u_req     = 2'b01;
    bus.u_info[0] = mk_req(32'h610);
    flush         = 1'b1;
    #1;
    chk("flush_aok", 32'(bus.u_addr_ok), 32'd0);
    chk("flush_dreq", 32'(bus.d_req), 32'd0);
    tick();
    flush     = 1'b0;
    bus.u_req = 2'b00;
    #1;
    chk("flush_idle0", 32'(idle), 32'd0);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    resp(2'b01, 32'h0000_6041, 32'h0, "flush_r0");
    resp(2'b01, 32'h0000_6081, 32'h0, "flush_r1");
    chk("flush_idle1", 32'(idle), 32'd1);
    chk("flush_dreq_after", 32'(bus.d_req), 32'd0);

    // asynchronous reset while in SPLIT
    bus.u_req     = 2'b11;
    bus.u_info[0] = mk_req(32'h700);
    bus.u_info[1] = mk_req(32'h800);
    tick();
    bus.u_req     = 2'b00;
    bus.d_addr_ok = 2'b01;
    tick();
    clr_inputs();
    #1;
    chk("rs_state_pre", 32'(dbg_state), 32'(ST_SPLIT));
    #1;
    resetn = 1'b0;
    #1;
    chk("rs_idle",  32'(idle), 32'd1);
    chk("rs_dreq",  32'(bus.d_req), 32'd0);
    chk("rs_state", 32'(dbg_state), 32'(ST_ISSUE));
    chk("rs_dok",   32'(bus.u_data_ok), 32'd0);
    tick();
    resetn = 1'b1;
    bus.u_req     = 2'b01;
    bus.u_info[0] = mk_req(32'h900);
    #1;
    chk("rs_aok", 32'(bus.u_addr_ok), 32'd1);
    tick();
    bus.u_req = 2'b00;
    #1;
    chk("rs_dreq_new", 32'(bus.d_req), 32'd1);
    chk("rs_va0", bus.d_info[0].va, 32'h900);
    bus.d_addr_ok = 2'b01;
    tick();
    bus.d_addr_ok = 2'b00;
    exp_q.push_back(2'b01);
    resp(2'b01, 32'h0000_9001, 32'h0, "rs_r0");
    chk("rs_idle_end", 32'(idle), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
